// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_TX serializer between NUM_REQ requesters.
// It latches the winning requester's byte and parity setup, then sequences Data_Valid and Busy.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BUSY_TO    = 4,
  localparam int IDW       = $clog2(NUM_REQ),
  localparam int CW        = $clog2(BUSY_TO + 1)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]            ACK,
  input  logic                          Busy,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          Data_Valid,
  output logic                          PAR_EN,
  output logic                          PAR_TYP,
  output logic [IDW-1:0]                GRANT_ID,
  output logic                          ARB_BUSY,
  output logic                          TO_ERR
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam logic [IDW:0]         NREQ_W   = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0]       LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);
  localparam logic [CW-1:0]        TO_LIMIT = CW'(BUSY_TO);

  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_word[g] = REQ_DATA[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [1:0]            state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic                  arb_busy_q, arb_busy_d;
  logic                  to_err_q, to_err_d;

  logic                  win_found;
  logic [IDW-1:0]        win_idx;
  logic [IDW:0]          sum;
  logic [IDW-1:0]        slot;

  // Search upward from ptr with wrap; the first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    slot      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      slot = sum[IDW-1:0];
      if (!win_found && REQ[slot]) begin
        win_found = 1'b1;
        win_idx   = slot;
      end
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    dv_d       = 1'b0;
    to_err_d   = 1'b0;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    grant_id_d = grant_id_q;
    case (state_q)
      ST_IDLE: begin
        if (!Busy && win_found) begin
          ack_d      = ONE_HOT0 << win_idx;
          dv_d       = 1'b1;
          p_data_d   = req_word[win_idx];
          par_en_d   = REQ_PAR_EN[win_idx];
          par_typ_d  = REQ_PAR_TYP[win_idx];
          grant_id_d = win_idx;
          ptr_d      = (win_idx == LAST_ID) ? '0 : win_idx + IDW'(1);
          cnt_d      = '0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (Busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_inc == TO_LIMIT) begin
          // The frame never started: drop the request, do not retry it.
          to_err_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!Busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    arb_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      grant_id_q <= '0;
      arb_busy_q <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      grant_id_q <= grant_id_d;
      arb_busy_q <= arb_busy_d;
      to_err_q   <= to_err_d;
    end
  end

  assign ACK        = ack_q;
  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign PAR_EN     = par_en_q;
  assign PAR_TYP    = par_typ_q;
  assign GRANT_ID   = grant_id_q;
  assign ARB_BUSY   = arb_busy_q;
  assign TO_ERR     = to_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART_TX Busy model
// (Busy rises the cycle after Data_Valid and stays high 11 cycles).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_par_en;
  logic [3:0]  req_par_typ;
  logic [3:0]  ack;
  logic        busy_w;
  logic [7:0]  p_data;
  logic        data_valid;
  logic        par_en;
  logic        par_typ;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        to_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic model_en = 1'b1;
  logic busy_m   = 1'b0;
  logic busy_ext = 1'b0;
  int   bcnt     = 0;

  uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BUSY_TO(4)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_DATA(req_data),
    .REQ_PAR_EN(req_par_en), .REQ_PAR_TYP(req_par_typ), .ACK(ack),
    .Busy(busy_w), .P_DATA(p_data), .Data_Valid(data_valid),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .GRANT_ID(grant_id),
    .ARB_BUSY(arb_busy), .TO_ERR(to_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) busy_m <= 1'b0;
    end else if (model_en && data_valid) begin
      busy_m <= 1'b1;
      bcnt   <= 11;
    end
  end

  assign busy_w = busy_m | busy_ext;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dv(input string name);
    int n = 0;
    while (!data_valid && n < 40) begin tick(); n++; end
    total++;
    if (data_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: Data_Valid never seen within bound", name);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((arb_busy || busy_w) && n < 60) begin tick(); n++; end
    total++;
    if (arb_busy !== 1'b0 || busy_w !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: arb_busy=%b busy=%b still high", arb_busy, busy_w);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0; req_par_en = '0; req_par_typ = '0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({ack, data_valid, p_data, par_en, par_typ, grant_id, arb_busy, to_err} !== 17'd0) begin
      bad++;
      $display("FAIL reset_vals: got %h want 0",
               {ack, data_valid, p_data, par_en, par_typ, grant_id, arb_busy, to_err});
    end
    tick();
    total++;
    if (arb_busy !== 1'b0 || data_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: arb_busy=%b dv=%b want 0 0", arb_busy, data_valid);
    end
  endtask

  task automatic test_single();
    int n;
    bit held_ok;
    req_data = 32'h0000_00A5; req_par_en = 4'b0001; req_par_typ = 4'b0000; req = 4'b0001;
    tick();
    total++;
    if (ack !== 4'b0001 || data_valid !== 1'b1) begin
      bad++; $display("FAIL single_ack: ack=%b dv=%b want 0001 1", ack, data_valid);
    end
    total++;
    if (p_data !== 8'hA5) begin
      bad++; $display("FAIL single_data: got %h want a5", p_data);
    end
    total++;
    if (par_en !== 1'b1 || par_typ !== 1'b0 || grant_id !== 2'd0 || arb_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_cfg: pe=%b pt=%b gid=%0d ab=%b want 1 0 0 1",
               par_en, par_typ, grant_id, arb_busy);
    end
    req = '0;
    tick();
    n = 0; held_ok = 1'b1;
    while (busy_w && n < 30) begin
      if (data_valid !== 1'b0 || p_data !== 8'hA5 || par_en !== 1'b1) held_ok = 1'b0;
      tick(); n++;
    end
    total++;
    if (n != 11) begin bad++; $display("FAIL single_busy_len: got %0d want 11", n); end
    total++;
    if (!held_ok) begin bad++; $display("FAIL single_hold: outputs changed during frame, want held"); end
    req = 4'b0001;
    total++;
    if (data_valid !== 1'b0) begin bad++; $display("FAIL single_k: dv=%b want 0", data_valid); end
    tick();
    total++;
    if (data_valid !== 1'b0 || arb_busy !== 1'b0) begin
      bad++; $display("FAIL single_k1: dv=%b ab=%b want 0 0", data_valid, arb_busy);
    end
    tick();
    total++;
    if (data_valid !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL single_k2: dv=%b gid=%0d want 1 0", data_valid, grant_id);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_all();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic exp_pe [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_pt [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int last = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req_data = 32'h4433_2211; req_par_en = 4'b1010; req_par_typ = 4'b0110; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_dv("all_dv");
      total++;
      if (grant_id !== 2'(exp_id[g]) || ack !== (4'b0001 << exp_id[g])) begin
        bad++; $display("FAIL all_grant[%0d]: gid=%0d ack=%b want %0d", g, grant_id, ack, exp_id[g]);
      end
      total++;
      if (p_data !== exp_d[g]) begin
        bad++; $display("FAIL all_data[%0d]: got %h want %h", g, p_data, exp_d[g]);
      end
      total++;
      if (par_en !== exp_pe[g] || par_typ !== exp_pt[g]) begin
        bad++; $display("FAIL all_par[%0d]: pe=%b pt=%b want %b %b", g, par_en, par_typ, exp_pe[g], exp_pt[g]);
      end
      if (g > 0) begin
        total++;
        if (cyc - last != 14) begin
          bad++; $display("FAIL all_gap[%0d]: got %0d want 14", g, cyc - last);
        end
      end
      last = cyc;
      tick();
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_wrap();
    req_data = 32'h4433_2211; req_par_en = '0; req_par_typ = '0;
    req = 4'b0100;
    wait_dv("wrap_dv2");
    total++;
    if (grant_id !== 2'd2) begin bad++; $display("FAIL wrap_pre: gid=%0d want 2", grant_id); end
    req = '0;
    wait_idle();
    req = 4'b0101;
    wait_dv("wrap_dv0");
    total++;
    if (grant_id !== 2'd0 || ack !== 4'b0001) begin
      bad++; $display("FAIL wrap_first: gid=%0d ack=%b want 0 0001", grant_id, ack);
    end
    tick();
    wait_dv("wrap_dvn");
    total++;
    if (grant_id !== 2'd2 || ack !== 4'b0100) begin
      bad++; $display("FAIL wrap_next: gid=%0d ack=%b want 2 0100", grant_id, ack);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_timeout();
    int t0, n;
    model_en = 1'b0;
    req_data = 32'h4400_5A00; req = 4'b0010;
    wait_dv("to_dv");
    total++;
    if (grant_id !== 2'd1 || p_data !== 8'h5A) begin
      bad++; $display("FAIL to_grant: gid=%0d data=%h want 1 5a", grant_id, p_data);
    end
    t0 = cyc;
    req = 4'b1000;
    n = 0;
    tick();
    while (!to_err && n < 20) begin tick(); n++; end
    total++;
    if (to_err !== 1'b1 || cyc - t0 != 4) begin
      bad++; $display("FAIL to_delay: to_err=%b delay=%0d want 1 4", to_err, cyc - t0);
    end
    total++;
    if (ack !== 4'b0000 || arb_busy !== 1'b0) begin
      bad++; $display("FAIL to_state: ack=%b ab=%b want 0000 0", ack, arb_busy);
    end
    model_en = 1'b1;
    tick();
    total++;
    if (data_valid !== 1'b1 || grant_id !== 2'd3 || p_data !== 8'h44 || to_err !== 1'b0) begin
      bad++;
      $display("FAIL to_regrant: dv=%b gid=%0d data=%h te=%b want 1 3 44 0",
               data_valid, grant_id, p_data, to_err);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_busy_blocked();
    bit quiet = 1'b1;
    busy_ext = 1'b1;
    req_data = 32'h0000_7E00; req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack !== 4'b0000 || data_valid !== 1'b0) quiet = 1'b0;
    end
    busy_ext = 1'b0;
    if (ack !== 4'b0000 || data_valid !== 1'b0) quiet = 1'b0;
    total++;
    if (!quiet) begin bad++; $display("FAIL blocked_quiet: grant seen while Busy high, want none"); end
    tick();
    total++;
    if (ack !== 4'b0010 || data_valid !== 1'b1 || p_data !== 8'h7E) begin
      bad++; $display("FAIL blocked_release: ack=%b dv=%b data=%h want 0010 1 7e", ack, data_valid, p_data);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n;
    bit quiet;
    req_data = 32'h4433_2211; req_par_en = 4'b1111; req_par_typ = 4'b1111; req = 4'b1000;
    wait_dv("mid_dv");
    total++;
    if (grant_id !== 2'd3) begin bad++; $display("FAIL mid_grant: gid=%0d want 3", grant_id); end
    req = '0;
    tick(); tick(); tick();
    total++;
    if (arb_busy !== 1'b1 || grant_id !== 2'd3) begin
      bad++; $display("FAIL mid_frame: ab=%b gid=%0d want 1 3", arb_busy, grant_id);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({ack, data_valid, p_data, par_en, par_typ, grant_id, arb_busy, to_err} !== 17'd0) begin
      bad++;
      $display("FAIL mid_reset: got %h want 0",
               {ack, data_valid, p_data, par_en, par_typ, grant_id, arb_busy, to_err});
    end
    req = 4'b1111;
    n = 0; quiet = 1'b1;
    while (busy_w && n < 30) begin
      if (data_valid !== 1'b0 || ack !== 4'b0000) quiet = 1'b0;
      tick(); n++;
    end
    if (data_valid !== 1'b0) quiet = 1'b0;
    total++;
    if (!quiet || busy_w) begin bad++; $display("FAIL mid_blocked: grant while Busy high, want none"); end
    tick();
    total++;
    if (ack !== 4'b0001 || grant_id !== 2'd0 || p_data !== 8'h11 || data_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_first: ack=%b gid=%0d data=%h dv=%b want 0001 0 11 1",
               ack, grant_id, p_data, data_valid);
    end
    req = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_wrap();
    test_timeout();
    test_busy_blocked();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
